prbs_checker_8bit: RTL and testbench

PRBS_CHECKER_8BIT -- requirements
Module: prbs_checker_8bit

---
 rtl/prbs_checker_8bit.sv | 140 ++++++++++++++
 tb/tb_prbs_checker_8bit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker_8bit.sv
// prbs_checker_8bit: serial PRBS checker for the 8-bit Fibonacci LFSR stream
// (b[n] = b[n-8] ^ b[n-7]). It seeds from the line, hunts for a clean run,
// then flywheels in lock while counting mismatches and watching a loss window.
module prbs_checker_8bit #(
   parameter int unsigned LOCK_COUNT  = 16,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned LOSS_WINDOW = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bit_valid,
   input  logic        bit_in,
   input  logic        clear_count,
   output logic        locked,
   output logic        error_pulse,
   output logic [15:0] error_count
);

   localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned WIN_W = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
   localparam int unsigned MIS_W = $clog2(LOSS_THRESH + 1);

   typedef enum logic [1:0] {ST_SEED, ST_HUNT, ST_LOCKED} state_t;

   state_t            state_q, state_d;
   logic [7:0]        hist_q, hist_d;
   logic [2:0]        seed_q, seed_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [MIS_W-1:0]  mis_q, mis_d;
   logic              locked_d, pulse_d;
   logic [15:0]       count_d;

   logic exp_bit_c, hunt_match_c, lock_mis_c, lock_hit_c, loss_c;

   // Expected bit and the per-state match/decision terms
   always_comb begin
      exp_bit_c    = hist_q[7] ^ hist_q[6];
      hunt_match_c = (bit_in == exp_bit_c) && (hist_q != 8'h00);
      lock_mis_c   = (bit_in != exp_bit_c);
      lock_hit_c   = (state_q == ST_HUNT) && bit_valid && hunt_match_c &&
                     (run_q == RUN_W'(LOCK_COUNT - 1));
      loss_c       = (state_q == ST_LOCKED) && bit_valid && lock_mis_c &&
                     (mis_q == MIS_W'(LOSS_THRESH - 1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_SEED;
      else        state_q <= state_d;
   end

   // Next-state logic; only valid bits can move the FSM
   always_comb begin
      state_d = state_q;
      if (bit_valid) begin
         case (state_q)
            ST_SEED:   if (seed_q == 3'd7) state_d = ST_HUNT;
            ST_HUNT:   if (lock_hit_c)     state_d = ST_LOCKED;
            ST_LOCKED: if (loss_c)         state_d = ST_SEED;
            default:                       state_d = ST_SEED;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      hist_d   = hist_q;
      seed_d   = seed_q;
      run_d    = run_q;
      win_d    = win_q;
      mis_d    = mis_q;
      pulse_d  = 1'b0;
      count_d  = error_count;
      locked_d = (state_d == ST_LOCKED);
      if (bit_valid) begin
         case (state_q)
            ST_SEED: begin
               hist_d = {hist_q[6:0], bit_in};
               seed_d = seed_q + 3'd1;
               run_d  = '0;
            end
            ST_HUNT: begin
               hist_d = {hist_q[6:0], bit_in};
               run_d  = hunt_match_c ? run_q + RUN_W'(1) : '0;
               if (lock_hit_c) begin
                  run_d = '0;
                  win_d = '0;
                  mis_d = '0;
               end
            end
            ST_LOCKED: begin
               // flywheel: the line bit never enters the history while locked
               hist_d = {hist_q[6:0], exp_bit_c};
               if (lock_mis_c) begin
                  pulse_d = 1'b1;
                  if (error_count != 16'hFFFF) count_d = error_count + 16'd1;
               end
               if (loss_c) begin
                  win_d  = '0;
                  mis_d  = '0;
                  seed_d = '0;
               end else if (win_q == WIN_W'(LOSS_WINDOW - 1)) begin
                  win_d = '0;
                  mis_d = '0;
               end else begin
                  win_d = win_q + WIN_W'(1);
                  mis_d = mis_q + MIS_W'(lock_mis_c);
               end
            end
            default: ;
         endcase
      end
      if (clear_count) count_d = '0;
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q      <= '0;
         seed_q      <= '0;
         run_q       <= '0;
         win_q       <= '0;
         mis_q       <= '0;
         locked      <= 1'b0;
         error_pulse <= 1'b0;
         error_count <= '0;
      end else begin
         hist_q      <= hist_d;
         seed_q      <= seed_d;
         run_q       <= run_d;
         win_q       <= win_d;
         mis_q       <= mis_d;
         locked      <= locked_d;
         error_pulse <= pulse_d;
         error_count <= count_d;
      end
   end

endmodule

// File: tb/tb_prbs_checker_8bit.sv
// Bench for prbs_checker_8bit: directed scenarios with a reference model
// feeding a scoreboard queue, plus directed end-of-scenario checks.
module tb_prbs_checker_8bit;

   localparam int unsigned LC = 16;
   localparam int unsigned LT = 4;
   localparam int unsigned LW = 32;

   typedef struct packed {
      logic        lck;
      logic        pls;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bit_valid = 1'b0;
   logic        bit_in = 1'b0;
   logic        clear_count = 1'b0;
   logic        locked;
   logic        error_pulse;
   logic [15:0] error_count;

   int n_assert = 0;
   int n_fail   = 0;
   exp_t sb_q[$];

   // reference model state
   int         m_state = 0;
   logic [7:0] m_h = 8'h00;
   int         m_seed = 0, m_run = 0, m_win = 0, m_mis = 0;
   int         m_cnt = 0;
   logic       m_pulse = 1'b0;
   logic [7:0] g = 8'h01;

   prbs_checker_8bit #(.LOCK_COUNT(LC), .LOSS_THRESH(LT), .LOSS_WINDOW(LW)) dut (
      .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
      .clear_count(clear_count), .locked(locked), .error_pulse(error_pulse),
      .error_count(error_count));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
      n_assert++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   // Reference behaviour for one clock cycle
   task automatic model(input logic r, input logic v, input logic b, input logic clr);
      logic e;
      logic good;
      m_pulse = 1'b0;
      if (!r) begin
         m_state = 0; m_h = 8'h00; m_seed = 0; m_run = 0;
         m_win = 0; m_mis = 0; m_cnt = 0;
         return;
      end
      if (v) begin
         e = m_h[7] ^ m_h[6];
         if (m_state == 0) begin
            m_h = {m_h[6:0], b};
            m_seed++;
            if (m_seed == 8) begin m_state = 1; m_seed = 0; m_run = 0; end
         end else if (m_state == 1) begin
            good = (b == e) && (m_h != 8'h00);
            m_h = {m_h[6:0], b};
            m_run = good ? m_run + 1 : 0;
            if (m_run == LC) begin m_state = 2; m_run = 0; m_win = 0; m_mis = 0; end
         end else begin
            m_h = {m_h[6:0], e};
            if (b != e) begin
               m_pulse = 1'b1;
               if (m_cnt < 65535) m_cnt++;
               m_mis++;
            end
            if (m_mis == LT) begin
               m_state = 0; m_seed = 0; m_win = 0; m_mis = 0;
            end else begin
               m_win++;
               if (m_win == LW) begin m_win = 0; m_mis = 0; end
            end
         end
      end
      if (clr) m_cnt = 0;
   endtask

   // Drive one cycle, push expectation, sample after the edge and compare
   task automatic step(input logic r, input logic v, input logic b, input logic clr);
      exp_t ex, got;
      rst_n = r; bit_valid = v; bit_in = b; clear_count = clr;
      model(r, v, b, clr);
      ex.lck = (m_state == 2);
      ex.pls = m_pulse;
      ex.cnt = 16'(m_cnt);
      sb_q.push_back(ex);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_assert++; n_fail++;
         $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
         got = sb_q.pop_front();
         chk("locked", 16'(locked), 16'(got.lck));
         chk("error_pulse", 16'(error_pulse), 16'(got.pls));
         chk("error_count", error_count, got.cnt);
      end
   endtask

   function automatic logic gen_bit();
      logic f;
      f = g[7] ^ g[6];
      g = {g[6:0], f};
      return f;
   endfunction

   task automatic send(input int n, input logic inv, input logic gaps);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b1, gen_bit() ^ inv, 1'b0);
         if (gaps) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   initial begin
      // reset
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_locked", 16'(locked), 16'h0);
      chk("rst_count", error_count, 16'h0);

      // clean stream: lock exactly after the 24th bit
      send(23, 1'b0, 1'b0);
      chk("pre_lock", 16'(locked), 16'h0);
      send(1, 1'b0, 1'b0);
      chk("lock_24", 16'(locked), 16'h1);
      chk("lock_cnt", error_count, 16'h0);

      // single inverted bit while locked
      send(5, 1'b0, 1'b0);
      send(1, 1'b1, 1'b0);
      chk("single_pulse", 16'(error_pulse), 16'h1);
      send(8, 1'b0, 1'b0);
      chk("single_cnt", error_count, 16'h1);
      chk("single_lock", 16'(locked), 16'h1);

      // roll window to a boundary, clear the count, then 4 errors -> loss
      send(17, 1'b0, 1'b0);
      step(1'b1, 1'b1, gen_bit(), 1'b1);
      chk("cleared", error_count, 16'h0);
      for (int k = 0; k < 4; k++) begin
         send(1, 1'b1, 1'b0);
         if (k < 3) send(3, 1'b0, 1'b0);
      end
      chk("loss_lock", 16'(locked), 16'h0);
      chk("loss_cnt", error_count, 16'h4);
      send(23, 1'b0, 1'b0);
      chk("relock_pre", 16'(locked), 16'h0);
      send(1, 1'b0, 1'b0);
      chk("relock", 16'(locked), 16'h1);
      chk("relock_cnt", error_count, 16'h4);

      // gapped valid: same results counted in valid bits
      step(1'b0, 1'b0, 1'b0, 1'b0);
      g = 8'h01;
      send(23, 1'b0, 1'b1);
      chk("gap_pre", 16'(locked), 16'h0);
      send(24 - 23, 1'b0, 1'b1);
      chk("gap_lock", 16'(locked), 16'h1);
      send(3, 1'b0, 1'b1);
      send(1, 1'b1, 1'b1);
      send(8, 1'b0, 1'b1);
      chk("gap_cnt", error_count, 16'h1);
      chk("gap_locked", 16'(locked), 16'h1);

      // constant zero never locks
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("zero_lock", 16'(locked), 16'h0);
      chk("zero_cnt", error_count, 16'h0);

      // clear with simultaneous mismatch, then reset while locked
      step(1'b0, 1'b0, 1'b0, 1'b0);
      g = 8'h01;
      send(24, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         send(1, 1'b1, 1'b0);
         send(1, 1'b0, 1'b0);
      end
      chk("three_cnt", error_count, 16'h3);
      step(1'b1, 1'b1, ~gen_bit(), 1'b1);
      chk("clr_pulse", 16'(error_pulse), 16'h1);
      chk("clr_cnt", error_count, 16'h0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("post_rst_lock", 16'(locked), 16'h0);
      chk("post_rst_pulse", 16'(error_pulse), 16'h0);
      chk("post_rst_cnt", error_count, 16'h0);
      // back in SEED: 23 clean bits must not lock
      g = 8'h01;
      send(23, 1'b0, 1'b0);
      chk("seed_after_rst", 16'(locked), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
